// File: rtl/present_round_iterator.sv
// Iterated 12-bit mini-PRESENT round controller: holds cipher state and round key,
// feeds an external sbox/key-add stage and applies the bit permutation each round.
module present_round_iterator #(
    parameter int ROUNDS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [11:0] io_in_state,
    input  logic [11:0] io_in_key,
    output logic [11:0] io_sbox_state,
    output logic [11:0] io_sbox_key,
    input  logic [11:0] io_sbox_out,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [11:0] io_out_data,
    output logic        io_busy,
    output logic [3:0]  io_round
);

    if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
        $error("present_round_iterator: ROUNDS must lie in 1..15");
    end

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t        fsm_r;
    logic [11:0] state_r;
    logic [11:0] key_r;
    logic [3:0]  cnt_r;
    logic        idle_r;
    logic        busy_r;
    logic        done_r;

    logic [11:0] perm_s;
    logic [11:0] key_next_s;
    logic [3:0]  cnt_inc_s;

    // Bit permutation: input bit i lands on output bit (3*i mod 11); bit 11 is fixed.
    function automatic logic [11:0] perm12(input logic [11:0] x);
        return {x[11], x[7], x[3], x[10], x[6], x[2],
                x[9],  x[5], x[1], x[8],  x[4], x[0]};
    endfunction

    // Next-round values derived from the stage output and the current key/counter.
    always_comb begin
        cnt_inc_s  = cnt_r + 4'd1;
        perm_s     = perm12(io_sbox_out);
        key_next_s = {key_r[6:0], key_r[11:7]} ^ {8'd0, cnt_inc_s};
    end

    // Round FSM with datapath registers and registered control flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_r   <= IDLE;
            state_r <= 12'd0;
            key_r   <= 12'd0;
            cnt_r   <= 4'd0;
            idle_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (io_in_valid) begin
                        state_r <= io_in_state;
                        key_r   <= io_in_key;
                        cnt_r   <= 4'd0;
                        fsm_r   <= RUN;
                        idle_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        fsm_r   <= IDLE;
                    end
                end
                RUN: begin
                    state_r <= perm_s;
                    key_r   <= key_next_s;
                    cnt_r   <= cnt_inc_s;
                    if (cnt_r == LAST_CNT) begin
                        fsm_r  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        fsm_r  <= RUN;
                    end
                end
                DONE: begin
                    // Ciphertext held in state_r until the consumer takes it.
                    if (io_out_ready) begin
                        fsm_r  <= IDLE;
                        done_r <= 1'b0;
                        idle_r <= 1'b1;
                    end else begin
                        fsm_r  <= DONE;
                    end
                end
                default: begin
                    fsm_r  <= IDLE;
                    idle_r <= 1'b1;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_in_ready   = idle_r & reset;
    assign io_busy       = busy_r;
    assign io_out_valid  = done_r;
    assign io_sbox_state = state_r;
    assign io_sbox_key   = key_r;
    assign io_out_data   = state_r;
    assign io_round      = cnt_r;

endmodule

// File: tb/tb_present_round_iterator.sv
// Bench for present_round_iterator: three instances (1, 2 and 8 rounds) each driven by a
// behavioural sbox/key-add stage; results compared with an arithmetic cipher model.
module tb_present_round_iterator;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- reference model ----------------
    function automatic logic [3:0] sbox4(input logic [3:0] v);
        case (v)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // External stage: key addition followed by the nibble sbox layer.
    function automatic logic [11:0] stage_f(input logic [11:0] s, input logic [11:0] k);
        logic [11:0] x;
        x = s ^ k;
        return {sbox4(x[11:8]), sbox4(x[7:4]), sbox4(x[3:0])};
    endfunction

    // Output bit j takes input bit (4*j mod 11), the inverse of i -> 3*i mod 11.
    function automatic logic [11:0] perm_ref(input logic [11:0] x);
        logic [11:0] y;
        y = 12'd0;
        for (int j = 0; j < 11; j++)
            y = y | (((x >> ((4 * j) % 11)) & 12'd1) << j);
        y = y | (x & 12'h800);
        return y;
    endfunction

    // Returns {final key, ciphertext}.
    function automatic logic [23:0] ref_enc(input logic [11:0] pt, input logic [11:0] k0,
                                            input int rounds);
        logic [11:0] s;
        logic [11:0] k;
        s = pt;
        k = k0;
        for (int r = 0; r < rounds; r++) begin
            s = perm_ref(stage_f(s, k));
            k = ((k << 5) | (k >> 7)) ^ 12'(r + 1);
        end
        return {k, s};
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // ---------------- DUT signals ----------------
    logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
    logic [11:0] in_state_1, in_key_1, sbox_state_1, sbox_key_1, sbox_out_1, out_data_1;
    logic [3:0]  round_1;
    logic        in_valid_2, in_ready_2, out_valid_2, out_ready_2, busy_2;
    logic [11:0] in_state_2, in_key_2, sbox_state_2, sbox_key_2, sbox_out_2, out_data_2;
    logic [3:0]  round_2;
    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
    logic [11:0] in_state_8, in_key_8, sbox_state_8, sbox_key_8, sbox_out_8, out_data_8;
    logic [3:0]  round_8;

    assign sbox_out_1 = stage_f(sbox_state_1, sbox_key_1);
    assign sbox_out_2 = stage_f(sbox_state_2, sbox_key_2);
    assign sbox_out_8 = stage_f(sbox_state_8, sbox_key_8);

    present_round_iterator #(.ROUNDS(1)) u_r1 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid_1), .io_in_ready(in_ready_1),
        .io_in_state(in_state_1), .io_in_key(in_key_1),
        .io_sbox_state(sbox_state_1), .io_sbox_key(sbox_key_1), .io_sbox_out(sbox_out_1),
        .io_out_valid(out_valid_1), .io_out_ready(out_ready_1), .io_out_data(out_data_1),
        .io_busy(busy_1), .io_round(round_1));

    present_round_iterator #(.ROUNDS(2)) u_r2 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid_2), .io_in_ready(in_ready_2),
        .io_in_state(in_state_2), .io_in_key(in_key_2),
        .io_sbox_state(sbox_state_2), .io_sbox_key(sbox_key_2), .io_sbox_out(sbox_out_2),
        .io_out_valid(out_valid_2), .io_out_ready(out_ready_2), .io_out_data(out_data_2),
        .io_busy(busy_2), .io_round(round_2));

    present_round_iterator #(.ROUNDS(8)) u_r8 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid_8), .io_in_ready(in_ready_8),
        .io_in_state(in_state_8), .io_in_key(in_key_8),
        .io_sbox_state(sbox_state_8), .io_sbox_key(sbox_key_8), .io_sbox_out(sbox_out_8),
        .io_out_valid(out_valid_8), .io_out_ready(out_ready_8), .io_out_data(out_data_8),
        .io_busy(busy_8), .io_round(round_8));

    // ---------------- scoreboard for the 8-round instance ----------------
    typedef struct {
        logic [11:0] ct;
        int          acc;
    } blk_t;

    blk_t q[$];
    int   last_acc = -1;
    bit   seen     = 1'b0;

    // Called at the sample point before an edge, after this cycle's inputs are driven.
    task automatic monitor8(input int mode);
        blk_t        b;
        logic [23:0] r;
        if (busy_8) begin
            check_eq("run_inflight", 12'(q.size()), 12'd1);
            if (q.size() > 0)
                check_eq("run_round", 12'(round_8), 12'(cyc - q[0].acc - 1));
            check_eq("run_in_ready", 12'(in_ready_8), 12'd0);
        end
        if (out_valid_8) begin
            check_eq("out_inflight", 12'(q.size()), 12'd1);
            if (q.size() > 0) begin
                if (!seen) begin
                    // DONE is entered 8 edges after the accepting edge.
                    check_eq("latency", 12'(cyc - q[0].acc), 12'd9);
                    seen = 1'b1;
                end
                check_eq("ciphertext", out_data_8, q[0].ct);
                check_eq("done_round", 12'(round_8), 12'd8);
                check_eq("done_in_ready", 12'(in_ready_8), 12'd0);
                if (out_ready_8) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
        if (in_ready_8 && in_valid_8) begin
            if (mode == 0 && last_acc >= 0)
                check_eq("accept_gap", 12'(cyc - last_acc), 12'd10);
            last_acc = cyc;
            r        = ref_enc(in_state_8, in_key_8, 8);
            b.ct     = r[11:0];
            b.acc    = cyc;
            q.push_back(b);
        end
    endtask

    // mode 0: in_valid/out_ready tied high; mode 1: both randomized.
    task automatic run8(input int ncyc, input int mode);
        last_acc = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (mode == 0) begin
                in_valid_8  = 1'b1;
                out_ready_8 = 1'b1;
            end else begin
                in_valid_8  = ($urandom_range(0, 2) != 0);
                out_ready_8 = ($urandom_range(0, 3) != 0);
            end
            in_state_8 = 12'($urandom);
            in_key_8   = 12'($urandom);
            monitor8(mode);
            step();
        end
    endtask

    task automatic drain8();
        in_valid_8  = 1'b0;
        out_ready_8 = 1'b1;
        for (int b = 0; b < 30 && q.size() > 0; b++) begin
            monitor8(1);
            step();
        end
        check_eq("drain_empty", 12'(q.size()), 12'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] pt;
        logic [23:0] r;
        logic [11:0] held;

        in_valid_1 = 1'b0; in_state_1 = 12'd0; in_key_1 = 12'd0; out_ready_1 = 1'b0;
        in_valid_2 = 1'b0; in_state_2 = 12'd0; in_key_2 = 12'd0; out_ready_2 = 1'b0;
        in_valid_8 = 1'b0; in_state_8 = 12'd0; in_key_8 = 12'd0; out_ready_8 = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_in_ready", 12'(in_ready_8), 12'd0);
        check_eq("rst_busy", 12'(busy_8), 12'd0);
        check_eq("rst_out_valid", 12'(out_valid_8), 12'd0);
        check_eq("rst_round", 12'(round_8), 12'd0);
        check_eq("rst_data", out_data_8, 12'd0);
        check_eq("rst_key", sbox_key_8, 12'd0);
        check_eq("rst_in_ready_r1", 12'(in_ready_1), 12'd0);
        reset = 1'b1;
        step();
        check_eq("idle_in_ready", 12'(in_ready_8), 12'd1);
        check_eq("idle_in_ready_r1", 12'(in_ready_1), 12'd1);

        // Single round, all-zero block
        in_valid_1 = 1'b1; in_state_1 = 12'h000; in_key_1 = 12'h000; out_ready_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        check_eq("r1_busy", 12'(busy_1), 12'd1);
        check_eq("r1_round0", 12'(round_1), 12'd0);
        step();
        check_eq("r1_valid", 12'(out_valid_1), 12'd1);
        check_eq("r1_data", out_data_1, 12'hFC0);
        check_eq("r1_round", 12'(round_1), 12'd1);
        step();
        check_eq("r1_valid_drop", 12'(out_valid_1), 12'd0);
        check_eq("r1_in_ready", 12'(in_ready_1), 12'd1);

        // Key schedule over two rounds, then backpressure
        pt = 12'($urandom);
        r  = ref_enc(pt, 12'h001, 2);
        in_valid_2 = 1'b1; in_state_2 = pt; in_key_2 = 12'h001; out_ready_2 = 1'b0;
        step();
        check_eq("r2_key0", sbox_key_2, 12'h001);
        check_eq("r2_state0", sbox_state_2, pt);
        in_state_2 = 12'($urandom); in_key_2 = 12'($urandom);
        step();
        check_eq("r2_key1", sbox_key_2, 12'h021);
        check_eq("r2_round1", 12'(round_2), 12'd1);
        in_valid_2 = 1'b0;
        step();
        check_eq("r2_valid", 12'(out_valid_2), 12'd1);
        check_eq("r2_key_final", sbox_key_2, 12'h422);
        check_eq("r2_data", out_data_2, r[11:0]);
        check_eq("r2_round", 12'(round_2), 12'd2);
        held = out_data_2;
        for (int i = 0; i < 10; i++) begin
            in_valid_2 = 1'($urandom_range(0, 1));
            step();
            check_eq("bp_valid", 12'(out_valid_2), 12'd1);
            check_eq("bp_data", out_data_2, held);
            check_eq("bp_in_ready", 12'(in_ready_2), 12'd0);
        end
        in_valid_2  = 1'b0;
        out_ready_2 = 1'b1;
        step();
        check_eq("bp_release_valid", 12'(out_valid_2), 12'd0);
        check_eq("bp_release_in_ready", 12'(in_ready_2), 12'd1);

        // Back-to-back with changing inputs, then random handshakes
        run8(100, 0);
        run8(400, 1);
        drain8();

        // Reset during round 4
        in_valid_8 = 1'b1; in_state_8 = 12'($urandom); in_key_8 = 12'($urandom);
        out_ready_8 = 1'b1;
        monitor8(1);
        step();
        in_valid_8 = 1'b0;
        for (int b = 0; b < 20 && round_8 != 4'd4; b++) begin
            monitor8(1);
            step();
        end
        check_eq("reach_round4", 12'(round_8), 12'd4);
        reset = 1'b0;
        step();
        check_eq("mid_rst_in_ready", 12'(in_ready_8), 12'd0);
        check_eq("mid_rst_busy", 12'(busy_8), 12'd0);
        check_eq("mid_rst_valid", 12'(out_valid_8), 12'd0);
        check_eq("mid_rst_round", 12'(round_8), 12'd0);
        check_eq("mid_rst_state", sbox_state_8, 12'd0);
        check_eq("mid_rst_key", sbox_key_8, 12'd0);
        q.delete();
        seen  = 1'b0;
        reset = 1'b1;
        step();
        check_eq("post_rst_in_ready", 12'(in_ready_8), 12'd1);
        check_eq("post_rst_no_valid", 12'(out_valid_8), 12'd0);
        run8(80, 1);
        drain8();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present_round_iterator.md
Name: present_round_iterator

Overview:
- Sequential round controller that sits directly downstream of the 3-nibble PRESENT sbox/key-add stage (PresentSbox_keyAdd_parallel) and wraps it into an iterated 12-bit mini-PRESENT cipher core.
- Holds the cipher state and round-key registers and drives the stage's state and key inputs.
- Consumes the stage output, applies the 12-bit bit-permutation layer, and writes the result back each round.
- Ready/valid handshakes on both the plaintext and ciphertext sides.

Parameters:
- ROUNDS, 8, number of sbox/key-add/permute rounds per block; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- io_in_valid  in  1  plaintext/key offered.
- io_in_ready  out  1  block can accept a new plaintext/key.
- io_in_state  in  12  plaintext.
- io_in_key  in  12  initial round key.
- io_sbox_state  out  12  to stage io_state; equals the state register.
- io_sbox_key  out  12  to stage io_key; equals the key register.
- io_sbox_out  in  12  from stage io_out.
- io_out_valid  out  1  ciphertext available.
- io_out_ready  in  1  consumer accepts the ciphertext.
- io_out_data  out  12  ciphertext; equals the state register.
- io_busy  out  1  high in RUN.
- io_round  out  4  current round counter.

Behaviour:
- Reset:
  - On a rising edge with reset=0: FSM goes to IDLE; state, key and counter registers are set to 0.
  - While reset=0, io_in_ready=0 (gated), io_out_valid=0 and io_busy=0.
  - Reset mid-RUN or in DONE aborts the block. The pending ciphertext is discarded and no out_valid pulse follows.
- FSM states: IDLE, RUN, DONE (registered). Only the FSM register drives the control outputs (no combinational path input to output):
  - io_in_ready = (IDLE)
  - io_busy = (RUN)
  - io_out_valid = (DONE)
- IDLE:
  - When io_in_valid is high: state <= io_in_state, key <= io_in_key, cnt <= 0, go to RUN.
  - Otherwise hold.
- RUN, every cycle:
  - state <= P(io_sbox_out).
  - key <= rotl12(key,5) XOR {8'b0, cnt+1}; the low 4 bits carry cnt+1.
  - cnt <= cnt+1.
  - If cnt == ROUNDS-1, go to DONE.
  - io_in_valid is ignored in RUN.
- Permutation P:
  - Output bit (3*i mod 11) = input bit i, for i = 0..10.
  - Output bit 11 = input bit 11.
- DONE:
  - io_out_valid=1, and io_out_data holds stable while valid and not ready.
  - When io_out_ready is high: go to IDLE.
  - The ready-to-valid path has a one-cycle bubble: in_ready rises the cycle after output acceptance. Simultaneous in/out acceptance is impossible by construction.
- Latency:
  - A block accepted at edge k enters DONE at edge k+ROUNDS.
  - At edge k+ROUNDS, io_out_valid goes high.
  - Throughput is one block per ROUNDS+2 cycles with out_ready tied high.
- io_round:
  - Equals cnt: 0..ROUNDS-1 during RUN, ROUNDS in DONE.
  - Held at its last value in IDLE until the next load, which resets it to 0.
- Counter: 4-bit, never wraps because ROUNDS<=15. ROUNDS outside 1..15 is an elaboration error.
- The combinational stage is external: io_sbox_out is sampled only in RUN and is a don't-care elsewhere.

Test Plan:
- Single round: ROUNDS=1, stage attached, plaintext 0x000, key 0x000.
  - Stage output is 0xCCC, which P maps to 0xFC0.
  - io_out_valid must rise 1 cycle after acceptance with io_out_data=0xFC0, io_round=1.
- Key schedule: ROUNDS=2, key 0x001.
  - io_sbox_key must read 0x001 in round 0 and 0x021 in round 1.
  - Final key register must be 0x422 (rotl5(0x021)=0x420 XOR 0x002).
- Backpressure: hold io_out_ready=0 for 10 cycles in DONE.
  - io_out_valid and io_out_data stay stable and io_in_ready stays 0.
  - Raising ready returns the FSM to IDLE; io_in_ready=1 the next cycle.
- Back-to-back blocks: ROUNDS=8, in_valid and out_ready tied high.
  - Acceptances occur every 10 cycles.
  - Every ciphertext matches the golden model; no duplicate or dropped output.
- Reset mid-operation: assert reset=0 during round 4.
  - At the next edge FSM=IDLE, all registers are 0, io_out_valid=0 and io_busy=0.
  - After release, a new block completes correctly.
- Input ignored while busy: toggle io_in_valid and change io_in_state/io_in_key during RUN.
  - Result is unaffected and io_in_ready stays 0.
